// File: rtl/matvec_sequencer.sv
// Sequences y = W*x over combinational-read tensor storage: row-major MAC in signed Q8.8,
// one saturated write per row, then a single-cycle done pulse.
module matvec_sequencer #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int R_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int C_W  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              sat,
  output logic [R_W-1:0]    w_sel_r,
  output logic [C_W-1:0]    w_sel_c,
  input  logic [15:0]       w_data,
  output logic [C_W-1:0]    x_sel,
  input  logic [15:0]       x_data,
  output logic              y_write,
  output logic [R_W-1:0]    y_sel,
  output logic [15:0]       y_data
);
  localparam int ACC_W = 32 + C_W + 1;
  localparam logic [R_W-1:0] LAST_R = R_W'(ROWS - 1);
  localparam logic [C_W-1:0] LAST_C = C_W'(COLS - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                   r_state, w_next;
  logic [R_W-1:0]           r_row;
  logic [C_W-1:0]           r_col;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_sat;

  logic signed [31:0]       w_prod;
  logic signed [ACC_W-1:0]  w_shift;
  logic                     w_fits;
  logic [15:0]              w_clamp;

  assign w_prod  = $signed(w_data) * $signed(x_data);
  assign w_shift = r_acc >>> 8;
  // Result fits in 16 bits only when every bit above bit 15 matches the sign.
  assign w_fits  = (&w_shift[ACC_W-1:15]) | ~(|w_shift[ACC_W-1:15]);
  assign w_clamp = w_fits ? w_shift[15:0] : (w_shift[ACC_W-1] ? 16'h8000 : 16'h7FFF);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_MAC;
      S_MAC:   if (r_col == LAST_C) w_next = S_WRITE;
      S_WRITE: w_next = (r_row == LAST_R) ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: if (start) begin
          r_row <= '0;
          r_col <= '0;
          r_acc <= '0;
          r_sat <= 1'b0;
        end
        S_MAC: begin
          r_acc <= r_acc + {{(ACC_W-32){w_prod[31]}}, w_prod};
          if (r_col != LAST_C) r_col <= r_col + C_W'(1);
        end
        S_WRITE: begin
          if (!w_fits) r_sat <= 1'b1;
          r_acc <= '0;
          r_col <= '0;
          if (r_row != LAST_R) r_row <= r_row + R_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state/counters only; inputs never reach them combinationally.
  always_comb begin
    busy    = (r_state != S_IDLE);
    done    = (r_state == S_DONE);
    sat     = r_sat;
    w_sel_r = '0;
    w_sel_c = '0;
    x_sel   = '0;
    y_write = 1'b0;
    y_sel   = '0;
    y_data  = '0;
    if (r_state == S_MAC) begin
      w_sel_r = r_row;
      w_sel_c = r_col;
      x_sel   = r_col;
    end
    if (r_state == S_WRITE) begin
      y_write = 1'b1;
      y_sel   = r_row;
      y_data  = w_clamp;
    end
  end
endmodule

// File: tb/tb_matvec_sequencer.sv
// Bench for matvec_sequencer: cycle-by-cycle compare against a timeline/arithmetic model,
// plus literal per-run expectations on written values, write/done timing and sat.
module tb_matvec_sequencer;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int PER  = COLS + 1;
  localparam int RUN  = ROWS * PER + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, sat, y_write;
  logic [1:0]  w_sel_r, w_sel_c, x_sel, y_sel;
  logic [15:0] w_data, x_data, y_data;

  logic signed [15:0] Wm [ROWS][COLS];
  logic signed [15:0] Xm [COLS];

  assign w_data = Wm[w_sel_r][w_sel_c];
  assign x_data = Xm[x_sel];

  matvec_sequencer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .sat(sat),
    .w_sel_r(w_sel_r), .w_sel_c(w_sel_c), .w_data(w_data), .x_sel(x_sel), .x_data(x_data),
    .y_write(y_write), .y_sel(y_sel), .y_data(y_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Row result straight from the arithmetic definition: exact sum, floor shift, clamp.
  function automatic logic [15:0] row_y(input int r, output bit s);
    longint acc = 0;
    for (int c = 0; c < COLS; c++) acc += longint'(Wm[r][c]) * longint'(Xm[c]);
    acc = acc >>> 8;
    s = 1'b0;
    if (acc > 32767) begin s = 1'b1; return 16'h7FFF; end
    if (acc < -32768) begin s = 1'b1; return 16'h8000; end
    return acc[15:0];
  endfunction

  int run_s = -1;
  bit sat_m = 1'b0;
  logic [15:0] ywr[$];
  int wr_t[$], done_t[$];
  int busy_n = 0;

  always @(negedge clk) if (chk_en) begin
    int t, p, k;
    bit act, mac, wr, s;
    logic [15:0] ey;
    t = cyc - run_s;
    act = (run_s >= 0) && (t >= 1) && (t <= RUN);
    mac = 0; wr = 0; p = 0; k = 0; s = 0; ey = 16'h0;
    if (act && t < RUN) begin
      p = (t - 1) / PER;
      k = (t - 1) % PER;
      mac = (k < COLS);
      wr  = (k == COLS);
    end
    if (wr) ey = row_y(p, s);
    chk("busy", busy, act);
    chk("done", done, act && t == RUN);
    chk("sat", sat, sat_m);
    chk("y_write", y_write, wr);
    chk("y_sel", y_sel, wr ? p : 0);
    chk("y_data", y_data, ey);
    chk("w_sel_r", w_sel_r, mac ? p : 0);
    chk("w_sel_c", w_sel_c, mac ? k : 0);
    chk("x_sel", x_sel, mac ? k : 0);
    if (y_write) begin ywr.push_back(y_data); wr_t.push_back(t); end
    if (done) done_t.push_back(t);
    if (busy) busy_n++;
    if (wr && s) sat_m = 1'b1;
    if (rst) begin
      run_s = -1;
      sat_m = 1'b0;
    end else if (!act && start) begin
      run_s = cyc;
      sat_m = 1'b0;
    end
  end

  task automatic fill(input logic [15:0] wv, input logic [15:0] xv);
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) Wm[r][c] = wv;
    for (int c = 0; c < COLS; c++) Xm[c] = xv;
  endtask

  task automatic fill_identity();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) Wm[r][c] = (r == c) ? 16'h0100 : 16'h0000;
    Xm[0] = 16'h0100; Xm[1] = 16'h0200; Xm[2] = 16'hFF00; Xm[3] = 16'h0080;
  endtask

  task automatic clear_log();
    ywr.delete(); wr_t.delete(); done_t.delete(); busy_n = 0;
  endtask

  // Pulse start, optionally a stray start at relative cycle ign, then run to quiet idle.
  task automatic run(input string nm, input logic [15:0] ye [ROWS], input logic se, input int ign, output int s);
    clear_log();
    @(posedge clk); #1 start = 1'b1; s = cyc;
    while (cyc < s + RUN + 2) begin
      @(posedge clk); #1;
      start = (ign > 0 && cyc == s + ign);
    end
    chk({nm, " writes"}, ywr.size(), ROWS);
    for (int i = 0; i < ROWS && i < ywr.size(); i++) begin
      chk({nm, " y"}, ywr[i], ye[i]);
      chk({nm, " wr_cycle"}, wr_t[i], PER * (i + 1));
    end
    chk({nm, " done_n"}, done_t.size(), 1);
    if (done_t.size() > 0) chk({nm, " done_cycle"}, done_t[0], 21);
    chk({nm, " busy_n"}, busy_n, 21);
    chk({nm, " sat"}, sat, se);
  endtask

  initial begin
    logic [15:0] ye [ROWS];
    int s;
    fill_identity();
    repeat (2) @(posedge clk);
    #1 chk_en = 1;
    @(posedge clk); #1 rst = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset y_write", y_write, 0);
    chk("reset sel", {w_sel_r, w_sel_c, x_sel, y_sel}, 0);

    ye = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    run("identity", ye, 1'b0, 8, s);

    fill(16'h7F00, 16'h7F00);
    ye = '{default: 16'h7FFF};
    run("sat_pos", ye, 1'b1, 0, s);
    fill(16'h8000, 16'h7F00);
    ye = '{default: 16'h8000};
    run("sat_neg", ye, 1'b1, 0, s);

    fill(16'hFF80, 16'h0100);
    ye = '{default: 16'hFE00};
    run("neg_half", ye, 1'b0, 0, s);
    fill(16'h0001, 16'h0001);
    ye = '{default: 16'h0000};
    run("tiny_pos", ye, 1'b0, 0, s);
    fill(16'hFFFF, 16'h0001);
    ye = '{default: 16'hFFFF};
    run("tiny_neg", ye, 1'b0, 0, s);

    // Reset mid-run after a saturating row has already been written.
    fill(16'h7F00, 16'h7F00);
    clear_log();
    @(posedge clk); #1 start = 1'b1; s = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < s + 7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst busy", busy, 0);
    chk("midrst sat", sat, 0);
    chk("midrst sel", {w_sel_r, w_sel_c, x_sel}, 0);
    while (cyc < s + RUN + 2) @(posedge clk);
    #1 chk("midrst writes", ywr.size(), 1);
    chk("midrst done_n", done_t.size(), 0);
    fill_identity();
    ye = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    run("post_rst", ye, 1'b0, 0, s);

    // Back-to-back: second start in the cycle right after done.
    fill(16'h7F00, 16'h7F00);
    clear_log();
    @(posedge clk); #1 start = 1'b1; s = cyc;
    @(posedge clk); #1 start = 1'b0;
    while (cyc < s + RUN + 1) @(posedge clk);
    #1 chk("b2b first sat", sat, 1);
    chk("b2b first writes", ywr.size(), ROWS);
    fill(16'hFF80, 16'h0100);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("b2b restart busy", busy, 1);
    chk("b2b restart sat", sat, 0);
    clear_log();
    while (cyc < s + 2 * (RUN + 1) + 1) @(posedge clk);
    #1 chk("b2b second writes", ywr.size(), ROWS);
    for (int i = 0; i < ywr.size(); i++) chk("b2b second y", ywr[i], 16'hFE00);
    chk("b2b second done_n", done_t.size(), 1);
    chk("b2b second sat", sat, 0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
